// File: rtl/mdu_divider.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, fixed WIDTH+2 edge latency.
// Quotient returns on Lo, remainder on Hi; sign fix-up and divide-by-zero are resolved in FIX.
`timescale 1ns/1ps
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             validIn,
  input  logic             sign,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             validOut,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             busy
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_dz, r_neg_q, r_neg_r;
  logic [WIDTH-1:0] r_a_raw, r_divr, r_rem, r_quot, r_hi, r_lo;

  logic [WIDTH-1:0] w_abs_a, w_abs_b;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_q_fix, w_r_fix;

  assign w_abs_a = (sign && SrcA[WIDTH-1]) ? -SrcA : SrcA;
  assign w_abs_b = (sign && SrcB[WIDTH-1]) ? -SrcB : SrcB;

  // Extra top bit on the difference is the borrow, so the compare survives a shifted remainder >= 2^WIDTH.
  assign w_shift = {r_rem, r_quot[WIDTH-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_divr};
  assign w_ge    = ~w_diff[WIDTH+1];

  assign w_q_fix = r_neg_q ? -r_quot : r_quot;
  assign w_r_fix = r_neg_r ? -r_rem  : r_rem;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (validIn) w_next = CALC;
      CALC: if (r_cnt == CW'(WIDTH-1)) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dz    <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_a_raw <= '0;
      r_divr  <= '0;
      r_rem   <= '0;
      r_quot  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: if (validIn) begin
          r_a_raw <= SrcA;
          r_quot  <= w_abs_a;
          r_divr  <= w_abs_b;
          r_dz    <= (SrcB == '0);
          r_neg_q <= sign & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
          r_neg_r <= sign & SrcA[WIDTH-1];
          r_rem   <= '0;
          r_cnt   <= '0;
        end
        CALC: begin
          r_rem  <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_quot <= {r_quot[WIDTH-2:0], w_ge};
          r_cnt  <= r_cnt + 1'b1;
        end
        FIX: begin
          // Divide by zero wins over any sign correction.
          r_lo <= r_dz ? '1      : w_q_fix;
          r_hi <= r_dz ? r_a_raw : w_r_fix;
        end
        default: ;
      endcase
    end
  end

  assign validOut = (r_state == DONE);
  assign busy     = (r_state != IDLE);
  assign Hi       = r_hi;
  assign Lo       = r_lo;

endmodule
